// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush controller with hazard statistics
//
// Purpose: resolves memory freeze, taken-branch flush and load-use bubble
// hazards into per-stage enable/flush controls, and tracks hazard statistics
// plus a sticky data-memory timeout error.
//
// Ports:
//   clk, rst (async, active-low)
//   pause_id, branch_ex, mem_req, mem_ack, clr_cnt   hazard / handshake inputs
//   pc_en, ifid_en, idex_en, exme_en, mewb_en        stage load enables
//   ifid_flush, idex_flush, mewb_flush               bubble insertion (overrides en)
//   mem_err                                          sticky memory timeout
//   stall_cnt, bubble_cnt, flush_cnt                 saturating statistics
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause_id,
  input  logic             branch_ex,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exme_en,
  output logic             mewb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mewb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {ST_RUN, ST_MWAIT, ST_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wait_cnt, w_wait_nxt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;
  logic             w_active, w_branch, w_loaduse;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_active    = 1'b0;
    w_branch    = 1'b0;
    w_loaduse   = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exme_en     = 1'b1;
    mewb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mewb_flush  = 1'b0;

    case (r_state)
      ST_RUN, ST_MWAIT: begin
        w_active = 1'b1;
        if (mem_req && !mem_ack) begin
          // Freeze: hold everything up to EX/ME, let WB retire once, then bubble.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exme_en    = 1'b0;
          mewb_flush = 1'b1;
          w_wait_nxt = r_wait_cnt + 8'd1;
          if (w_wait_nxt == TIMEOUT_C) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_MWAIT;
          end
        end else begin
          // Ack or dropped request releases; this cycle uses normal priority.
          w_wait_nxt  = 8'd0;
          w_state_nxt = ST_RUN;
          if (branch_ex) begin
            w_branch   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (pause_id) begin
            w_loaduse  = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      ST_HALT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        exme_en = 1'b0;
        mewb_en = 1'b0;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase

    // Reset forces bubbles into every stage regardless of state.
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exme_en    = 1'b0;
      mewb_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      mewb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= 8'd0;
      r_mem_err    <= 1'b0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_state_nxt == ST_HALT) begin
        r_mem_err <= 1'b1;
      end
      if (clr_cnt) begin
        r_stall_cnt  <= '0;
        r_bubble_cnt <= '0;
        r_flush_cnt  <= '0;
      end else begin
        if (w_active && !pc_en && !(&r_stall_cnt)) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        if (w_loaduse && !(&r_bubble_cnt)) begin
          r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
        if (w_branch && !(&r_flush_cnt)) begin
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mem_err    = r_mem_err;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized model-checked bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, p, b, q, a, c;

  logic pc_a, ife_a, ide_a, exe_a, mwe_a, iff_a, idf_a, mwf_a, err_a;
  logic [31:0] st_a, bu_a, fl_a;
  logic pc_b, ife_b, ide_b, exe_b, mwe_b, iff_b, idf_b, mwf_b, err_b;
  logic [3:0] st_b, bu_b, fl_b;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state, one slot per instance (0: TIMEOUT 16 / 32-bit, 1: TIMEOUT 4 / 4-bit).
  bit    m_halt[2];
  int    m_frz[2];
  longint m_stall[2], m_bub[2], m_fl[2];
  longint m_max[2] = '{64'hFFFF_FFFF, 64'd15};
  int    m_to[2]   = '{16, 4};

  bit in_burst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .pause_id(p), .branch_ex(b), .mem_req(q), .mem_ack(a), .clr_cnt(c),
    .pc_en(pc_a), .ifid_en(ife_a), .idex_en(ide_a), .exme_en(exe_a), .mewb_en(mwe_a),
    .ifid_flush(iff_a), .idex_flush(idf_a), .mewb_flush(mwf_a), .mem_err(err_a),
    .stall_cnt(st_a), .bubble_cnt(bu_a), .flush_cnt(fl_a)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .pause_id(p), .branch_ex(b), .mem_req(q), .mem_ack(a), .clr_cnt(c),
    .pc_en(pc_b), .ifid_en(ife_b), .idex_en(ide_b), .exme_en(exe_b), .mewb_en(mwe_b),
    .ifid_flush(iff_b), .idex_flush(idf_b), .mewb_flush(mwf_b), .mem_err(err_b),
    .stall_cnt(st_b), .bubble_cnt(bu_b), .flush_cnt(fl_b)
  );

  wire [7:0] ctl_a = {pc_a, ife_a, ide_a, exe_a, mwe_a, iff_a, idf_a, mwf_a};
  wire [7:0] ctl_b = {pc_b, ife_b, ide_b, exe_b, mwe_b, iff_b, idf_b, mwf_b};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Controls ordered {pc, ifid_en, idex_en, exme_en, mewb_en, ifid_fl, idex_fl, mewb_fl}.
  function automatic logic [7:0] exp_ctl(input bit halted, input logic r_i, p_i, b_i, q_i, a_i);
    if (!r_i)         return 8'b0000_0111;
    if (halted)       return 8'b0000_0000;
    if (q_i && !a_i)  return 8'b0000_1001;
    if (b_i)          return 8'b1111_1110;
    if (p_i)          return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic step(input logic r_i, p_i, b_i, q_i, a_i, c_i);
    bit frz;
    @(negedge clk);
    rst = r_i; p = p_i; b = b_i; q = q_i; a = a_i; c = c_i;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!r_i) begin
        m_halt[k] = 0; m_frz[k] = 0; m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
      end
      chk($sformatf("ctl%0d", k), (k == 0) ? ctl_a : ctl_b, exp_ctl(m_halt[k], r_i, p_i, b_i, q_i, a_i));
      chk($sformatf("err%0d", k), (k == 0) ? err_a : err_b, m_halt[k]);
      chk($sformatf("stall%0d", k), (k == 0) ? st_a : st_b, m_stall[k]);
      chk($sformatf("bubble%0d", k), (k == 0) ? bu_a : bu_b, m_bub[k]);
      chk($sformatf("flush%0d", k), (k == 0) ? fl_a : fl_b, m_fl[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r_i) begin
        frz = q_i && !a_i;
        if (c_i) begin
          m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
        end else if (!m_halt[k]) begin
          if (frz || (!b_i && p_i)) m_stall[k] = sat_inc(m_stall[k], m_max[k]);
          if (!frz && !b_i && p_i)  m_bub[k]   = sat_inc(m_bub[k], m_max[k]);
          if (!frz && b_i)          m_fl[k]    = sat_inc(m_fl[k], m_max[k]);
        end
        if (!m_halt[k]) begin
          if (frz) begin
            m_frz[k]++;
            if (m_frz[k] == m_to[k]) m_halt[k] = 1;
          end else begin
            m_frz[k] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; p = 1'b0; b = 1'b0; q = 1'b0; a = 1'b0; c = 1'b0;
    // reset, then load-use, branch-over-pause
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // 3-cycle memory wait, then ack
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    // branch held through a 2-cycle freeze
    for (int i = 0; i < 2; i++) step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0);
    // release by dropping mem_req
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // 15 frozen cycles then ack: releases A, B already halted
    for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // 16 frozen cycles: A halts from cycle 17
    for (int i = 0; i < 18; i++) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset mid-freeze with branch pending
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // saturation of the 4-bit counters, then clear with pause
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    // randomized traffic
    in_burst = 0;
    for (int i = 0; i < 2000; i++) begin
      logic rr, pp, bb, qq, aa, cc;
      rr = ($urandom_range(0, 39) != 0);
      pp = ($urandom_range(0, 2) == 0);
      bb = ($urandom_range(0, 4) == 0);
      cc = ($urandom_range(0, 49) == 0);
      if (in_burst) begin
        qq = ($urandom_range(0, 15) != 0);
        aa = qq && ($urandom_range(0, 4) == 0);
        if (!qq || aa) in_burst = 0;
      end else begin
        qq = ($urandom_range(0, 5) == 0);
        aa = qq && ($urandom_range(0, 2) == 0);
        if (qq && !aa) in_burst = 1;
      end
      if (!rr) in_burst = 0;
      step(rr, pp, bb, qq, aa, cc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline stall/flush controller for the 5-stage CPU. It consumes the load-use `pause` produced by the register file and the taken-branch indication from EX. It also handshakes with data memory for multi-cycle accesses in ME. It drives per-stage enable/flush controls for PC, IF/ID, ID/EX, EX/ME and ME/WB, so that inserted bubbles clear the `we_*` forwarding qualifiers the register file sees. It also maintains saturating hazard statistics and a sticky memory-timeout error.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive frozen cycles allowed while waiting on data memory (legal range 2..255).
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pause_id  in  1  load-use hazard from the register file; the ID instruction needs a load result still in EX.
- branch_ex  in  1  taken branch/jump resolved in EX this cycle.
- mem_req  in  1  ME holds a load/store needing data memory.
- mem_ack  in  1  data memory completes the ME access this cycle.
- clr_cnt  in  1  synchronous clear of the statistics counters.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exme_en, mewb_en  out  1 each  pipeline register load enables.
- ifid_flush, idex_flush, mewb_flush  out  1 each  load a bubble (all control/we bits 0) instead of data; flush overrides en.
- mem_err  out  1  sticky timeout error.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  statistics.

## Operation
- States: RUN, MWAIT, HALT. Reset state is RUN. Outputs are combinational from state plus inputs (Mealy).
- Default outputs in RUN:
  - All en = 1.
  - All flush = 0.
- Priority in RUN and MWAIT, highest first:
  1. Memory freeze, when mem_req=1 and mem_ack=0:
     - pc_en, ifid_en, idex_en and exme_en = 0.
     - mewb_flush = 1, so the WB instruction retires once and bubbles follow.
  2. Branch, when branch_ex=1:
     - pc_en = 1, so the PC loads the target.
     - ifid_flush = 1 and idex_flush = 1.
     - exme_en and mewb_en = 1.
     - pause_id is ignored, because the ID instruction is killed.
  3. Load-use, when pause_id=1:
     - pc_en = 0 and ifid_en = 0.
     - idex_flush = 1.
     - EX/ME and ME/WB advance.
- State transitions:
  - RUN -> MWAIT on freeze.
  - MWAIT -> RUN on the first cycle with mem_ack=1. That cycle uses non-freeze priority, so a branch held in EX during the freeze flushes in that release cycle.
  - MWAIT -> HALT when the wait counter reaches TIMEOUT frozen cycles without an ack.
  - mem_req=1 and mem_ack=1 in the same RUN cycle: no freeze and no state change.
  - mem_req dropping to 0 in MWAIT is treated as release (same as an ack).
- Wait counter: 8 bits, internal.
  - Counts consecutive frozen cycles, including the RUN cycle that detected the freeze.
  - Cleared on return to RUN.
- HALT:
  - All en = 0, all flush = 0.
  - mem_err = 1.
  - Exited only by reset.
- Statistics:
  - stall_cnt increments each cycle pc_en=0 in RUN or MWAIT. It does not count in HALT.
  - bubble_cnt increments each load-use bubble cycle (priority 3 taken).
  - flush_cnt increments each branch flush cycle.
  - All counters saturate at all-ones.
  - clr_cnt has priority over increment.

## Timing
- rst low: state RUN, wait counter 0, mem_err 0, all counters 0. While rst is low: all en = 0 and all flush = 1, forcing bubbles.
- Control outputs have zero latency: they respond in the same cycle as the inputs.
- State, counters and mem_err update on the rising clk edge.
- Freeze length equals the number of cycles mem_ack is low while mem_req is high. The release cycle is not frozen.
- With TIMEOUT=16:
  - An ack in frozen cycle 16 releases normally.
  - No ack by the end of frozen cycle 16 gives HALT from cycle 17.
- Reset asserted mid-freeze: immediate RUN on deassertion, with no pending flush retained.
- Statistics are visible one cycle after the event.

## Test plan
- Load-use: pause_id=1 for one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1, exme_en=1 that cycle; next cycle all en=1; bubble_cnt=1, stall_cnt=1.
- Branch beats pause: branch_ex=1 and pause_id=1 together -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1, bubble_cnt=0.
- Memory wait: mem_req=1, mem_ack low for 3 cycles then high -> 3 frozen cycles with mewb_flush=1, state MWAIT for 2 cycles, RUN after ack; stall_cnt=3.
- Freeze plus branch: branch_ex held high through a 2-cycle freeze -> no flush during freeze; ifid_flush/idex_flush=1 only in the ack cycle; flush_cnt=1.
- Timeout: TIMEOUT=4, mem_req=1, mem_ack=0 forever -> HALT after 4 frozen cycles, mem_err=1, all en=0; async rst low -> mem_err=0, counters 0, state RUN.
- Counters: clr_cnt=1 together with pause_id=1 -> bubble_cnt=0 next cycle. A counter preloaded near all-ones (CNT_W=4) saturates at 15.
